serial_parallel_multi: RTL and testbench

Parametrised multi-lane serial-to-parallel converter with comma-based word alignment. Each lane deserialises its own bit stream into WIDTH-bit words and hunts for a COMMA symbol to fix the word boundary. A lane declares itself ACTIVE after COMMA_COUNT consecutive aligned commas. Once ACTIVE, the lane forwards payload words with a VALID strobe and drops COMMA/IDLE fill symbols. Sits at the receive side of the serial link, after the line and before the byte-level datapath.

---
 rtl/serial_parallel_pkg.sv | 21 ++
 rtl/serial_parallel_lane.sv | 112 +++++++++++
 rtl/serial_parallel_multi.sv | 40 ++++
 tb/tb_serial_parallel_multi.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_parallel_pkg.sv
// Shared definitions for the multi-lane serial-to-parallel converter:
// lane state encoding, default alignment/fill symbols and a counter sizing helper.
package serial_parallel_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCK   = 2'd1,
    ST_ACTIVE = 2'd2
  } lane_state_t;

  localparam logic [7:0] DEFAULT_COMMA = 8'hBC;
  localparam logic [7:0] DEFAULT_IDLE  = 8'h7C;

  // Bit counter width for a word of the given size; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_parallel_lane.sv
// One deserialiser lane: shifts in a serial bit per clock, hunts for the comma
// to fix the word boundary, locks after enough aligned commas, then forwards payload.
module serial_parallel_lane
  import serial_parallel_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COMMA       = WIDTH'(DEFAULT_COMMA),
  parameter logic [WIDTH-1:0] IDLE        = WIDTH'(DEFAULT_IDLE),
  parameter int               COMMA_COUNT = 4,
  parameter bit               MSB_FIRST   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int CW  = cnt_width(WIDTH);
  localparam int CCW = $clog2(COMMA_COUNT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CCW-1:0] CC_LAST  = CCW'(COMMA_COUNT - 1);

  lane_state_t      state_reg;
  logic [WIDTH-1:0] sr_reg;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt_reg;
  logic [CCW-1:0]   comma_cnt_reg;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             active_reg;
  logic             boundary;
  logic             is_comma;
  logic             is_fill;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_next = {sr_reg[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      assign sr_next = {data_in, sr_reg[WIDTH-1:1]};
    end
  endgenerate

  assign boundary = (cnt_reg == CNT_LAST);
  assign is_comma = (sr_next == COMMA);
  assign is_fill  = is_comma || (sr_next == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_HUNT;
      sr_reg        <= '0;
      cnt_reg       <= '0;
      comma_cnt_reg <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      sr_reg    <= sr_next;
      valid_reg <= 1'b0;
      cnt_reg   <= boundary ? '0 : cnt_reg + 1'b1;

      case (state_reg)
        // Any bit position may start a word here; a match pins the boundary to this edge.
        ST_HUNT: begin
          if (is_comma) begin
            cnt_reg       <= '0;
            comma_cnt_reg <= CCW'(1);
            if (COMMA_COUNT == 1) begin
              state_reg  <= ST_ACTIVE;
              active_reg <= 1'b1;
            end else begin
              state_reg <= ST_LOCK;
            end
          end
        end

        ST_LOCK: begin
          if (boundary) begin
            if (is_comma) begin
              comma_cnt_reg <= comma_cnt_reg + 1'b1;
              if (comma_cnt_reg == CC_LAST) begin
                state_reg  <= ST_ACTIVE;
                active_reg <= 1'b1;
              end
            end else begin
              comma_cnt_reg <= '0;
              state_reg     <= ST_HUNT;
            end
          end
        end

        // Locked for good: stray commas are just fill and never move the boundary.
        ST_ACTIVE: begin
          if (boundary) begin
            data_reg  <= sr_next;
            valid_reg <= !is_fill;
          end
        end

        default: begin
          state_reg <= ST_HUNT;
        end
      endcase
    end
  end

  assign data_out  = data_reg;
  assign valid_out = valid_reg;
  assign active    = active_reg;

endmodule

// File: rtl/serial_parallel_multi.sv
// Multi-lane serial-to-parallel converter with comma alignment: LANES independent
// deserialiser lanes packed onto shared output buses.
module serial_parallel_multi
  import serial_parallel_pkg::*;
#(
  parameter int               LANES       = 2,
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COMMA       = WIDTH'(DEFAULT_COMMA),
  parameter logic [WIDTH-1:0] IDLE        = WIDTH'(DEFAULT_IDLE),
  parameter int               COMMA_COUNT = 4,
  parameter bit               MSB_FIRST   = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [LANES-1:0]       DATA_IN,
  output logic [LANES*WIDTH-1:0] DATA_OUT,
  output logic [LANES-1:0]       VALID_OUT,
  output logic [LANES-1:0]       ACTIVE
);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      serial_parallel_lane #(
        .WIDTH      (WIDTH),
        .COMMA      (COMMA),
        .IDLE       (IDLE),
        .COMMA_COUNT(COMMA_COUNT),
        .MSB_FIRST  (MSB_FIRST)
      ) u_lane (
        .clk      (CLK),
        .rst_n    (RESET),
        .data_in  (DATA_IN[gi]),
        .data_out (DATA_OUT[gi*WIDTH +: WIDTH]),
        .valid_out(VALID_OUT[gi]),
        .active   (ACTIVE[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_serial_parallel_multi.sv
// Bench for serial_parallel_multi: an MSB-first two-lane instance and an LSB-first
// single-lane instance driven from per-lane bit queues, with a payload scoreboard.
module tb_serial_parallel_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  din_m;
  logic [15:0] dout_m;
  logic [1:0]  val_m;
  logic [1:0]  act_m;
  logic [0:0]  din_l;
  logic [7:0]  dout_l;
  logic [0:0]  val_l;
  logic [0:0]  act_l;

  always #5 clk = ~clk;

  serial_parallel_multi #(
    .LANES(2), .WIDTH(8), .COMMA(8'hBC), .IDLE(8'h7C), .COMMA_COUNT(4), .MSB_FIRST(1'b1)
  ) u_msb (
    .CLK(clk), .RESET(rst_n), .DATA_IN(din_m), .DATA_OUT(dout_m), .VALID_OUT(val_m), .ACTIVE(act_m)
  );

  serial_parallel_multi #(
    .LANES(1), .WIDTH(8), .COMMA(8'hBC), .IDLE(8'h7C), .COMMA_COUNT(4), .MSB_FIRST(1'b0)
  ) u_lsb (
    .CLK(clk), .RESET(rst_n), .DATA_IN(din_l), .DATA_OUT(dout_l), .VALID_OUT(val_l), .ACTIVE(act_l)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Lanes 0,1 belong to u_msb; lane 2 is the single lane of u_lsb.
  bit         bq[3][$];
  logic [7:0] expq[3][$];

  typedef struct {
    int         test;
    int         lane;
    logic [7:0] word;
    bit         exp_valid;
  } vec_t;
  vec_t tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic lane_act(input int i);
    if (i < 2) return act_m[i];
    return act_l[0];
  endfunction

  function automatic logic lane_valid(input int i);
    if (i < 2) return val_m[i];
    return val_l[0];
  endfunction

  function automatic logic [7:0] lane_data(input int i);
    if (i < 2) return dout_m[i*8 +: 8];
    return dout_l;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_word(input int lane, input logic [7:0] w, input bit exp_valid);
    for (int k = 0; k < 8; k++) bq[lane].push_back((lane < 2) ? w[7-k] : w[k]);
    if (exp_valid) expq[lane].push_back(w);
  endtask

  task automatic push_zeros(input int lane, input int n);
    for (int k = 0; k < n; k++) bq[lane].push_back(1'b0);
  endtask

  task automatic apply_table(input int test);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].test == test) push_word(tbl[i].lane, tbl[i].word, tbl[i].exp_valid);
  endtask

  task automatic add(input int test, input int lane, input logic [7:0] w, input bit v, input int n);
    vec_t e;
    for (int k = 0; k < n; k++) begin
      e.test = test; e.lane = lane; e.word = w; e.exp_valid = v;
      tbl.push_back(e);
    end
  endtask

  // Reset at a negedge, release at a later negedge; caller loads stimulus right after.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) bq[i].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // First bit of a load made at cycle load_cyc is sampled at the edge ending in load_cyc+2.
  task automatic wait_active(input string name, input int lane, input int load_cyc, input int last_bit);
    bit seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (lane_act(lane)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got ACTIVE never set, required rise at cycle %0d", name, load_cyc + 2 + last_bit);
    end else begin
      check(name, cyc, load_cyc + 2 + last_bit);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((bq[0].size() + bq[1].size() + bq[2].size()) > 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got stimulus still pending, required drained", name);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("%s_missing_words_lane%0d", name, i), expq[i].size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_dout_m"}, dout_m, 0);
    check({name, "_valid_m"}, val_m, 0);
    check({name, "_active_m"}, act_m, 0);
    check({name, "_dout_l"}, dout_l, 0);
    check({name, "_valid_l"}, val_l, 0);
    check({name, "_active_l"}, act_l, 0);
  endtask

  // Driver: one bit per lane per cycle, driven just after the edge; zeros when idle.
  initial begin
    bit b;
    din_m = '0;
    din_l = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        b = (bq[i].size() > 0) ? bq[i].pop_front() : 1'b0;
        if (i < 2) din_m[i] = b;
        else din_l[0] = b;
      end
    end
  end

  // Monitor: every VALID strobe must match the next expected payload word on that lane.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (lane_valid(i)) begin
          checks++;
          if (expq[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid lane%0d: got data %02h, required no VALID (cycle %0d)", i, lane_data(i), cyc);
          end else begin
            e = expq[i].pop_front();
            if (lane_data(i) !== e) begin
              errors++;
              $display("FAIL payload lane%0d: got %02h, required %02h (cycle %0d)", i, lane_data(i), e, cyc);
            end else begin
              $display("lane%0d word %02h valid at cycle %0d", i, e, cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l0;
    int l1;

    // Vector table: words per lane and whether each must appear as payload.
    add(2, 0, 8'hBC, 0, 4); add(2, 0, 8'h12, 1, 1); add(2, 0, 8'h7C, 0, 1); add(2, 0, 8'h34, 1, 1);
    add(3, 0, 8'hBC, 0, 2); add(3, 0, 8'h55, 0, 1); add(3, 0, 8'hBC, 0, 4);
    add(3, 0, 8'h66, 1, 1); add(3, 0, 8'h7C, 0, 1);
    add(4, 0, 8'hBC, 0, 4); add(4, 0, 8'hA5, 1, 1); add(4, 0, 8'h7C, 0, 3);
    add(4, 1, 8'hBC, 0, 4); add(4, 1, 8'h5A, 1, 1);
    add(5, 2, 8'hBC, 0, 4); add(5, 2, 8'h81, 1, 1); add(5, 2, 8'h7C, 0, 1);

    // Reset hold with random serial data.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++) bq[i].push_back(1'($urandom_range(0, 1)));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_all_zero($sformatf("reset_hold%0d", c));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");

    // 3-bit offset alignment, payload filtering of IDLE.
    do_reset();
    l0 = cyc;
    push_zeros(0, 3);
    apply_table(2);
    wait_active("align_offset3_active", 0, l0, 3 + 32 - 1);
    drain("align_offset3");

    // Broken lock returns to HUNT; needs a fresh run of four commas.
    do_reset();
    l0 = cyc;
    apply_table(3);
    wait_active("broken_lock_active", 0, l0, 7*8 - 1);
    drain("broken_lock");

    // Independent lanes, lane 1 delayed by 20 bits.
    do_reset();
    l0 = cyc;
    push_zeros(1, 20);
    apply_table(4);
    wait_active("lane0_active", 0, l0, 31);
    wait_active("lane1_active_lag", 1, l0, 20 + 31);
    drain("two_lanes");

    // LSB-first instance.
    do_reset();
    l0 = cyc;
    apply_table(5);
    wait_active("lsb_first_active", 2, l0, 31);
    drain("lsb_first");

    // Reset in the middle of a payload word while ACTIVE.
    do_reset();
    l0 = cyc;
    for (int k = 0; k < 4; k++) push_word(0, 8'hBC, 0);
    push_word(0, 8'h12, 1);
    push_word(0, 8'h99, 0);
    wait_active("midreset_first_active", 0, l0, 31);
    for (int n = 0; n < 100 && cyc < l0 + 2 + 43; n++) @(negedge clk);
    rst_n = 1'b0;
    bq[0].delete();
    @(negedge clk);
    check("midreset_active", act_m[0], 0);
    check("midreset_valid", val_m[0], 0);
    check("midreset_dout", dout_m[7:0], 0);
    check("midreset_queue", expq[0].size(), 0);
    rst_n = 1'b1;
    l1 = cyc;
    for (int k = 0; k < 3; k++) push_word(0, 8'hBC, 0);
    push_word(0, 8'h55, 0);
    for (int k = 0; k < 4; k++) push_word(0, 8'hBC, 0);
    push_word(0, 8'h42, 1);
    push_word(0, 8'h7C, 0);
    wait_active("midreset_relock_active", 0, l1, 8*8 - 1);
    drain("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
